// File: rtl/test_data_checker.sv
// Incrementing-pattern checker: paces read strobes to a data source and
// counts words, mismatches and the first mismatch for software.
module test_data_checker #(
  parameter int DATA_W     = 32,
  parameter int CNT_W      = 32,
  parameter int INTERVAL_W = 8
) (
  input  logic                  axi_clk,
  input  logic                  axi_reset,
  input  logic [31:0]           control,
  input  logic [CNT_W-1:0]      num_words,
  input  logic [INTERVAL_W-1:0] rd_interval,
  input  logic [DATA_W-1:0]     data,
  output logic                  data_rdStrobe,
  output logic [31:0]           status,
  output logic [CNT_W-1:0]      words_checked,
  output logic [CNT_W-1:0]      error_count,
  output logic [DATA_W-1:0]     first_err_expected,
  output logic [DATA_W-1:0]     first_err_actual
);

  typedef enum logic [1:0] {
    IDLE,
    SYNC,
    CHECK,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic                  enable;
  logic                  clear;
  logic                  active;
  logic                  strobe;
  logic                  mismatch;
  logic                  last_word;
  logic                  busy_q;
  logic                  done_q;
  logic                  synced_q;
  logic                  err_seen_q;
  logic [CNT_W-1:0]      words_q;
  logic [CNT_W-1:0]      words_nx;
  logic [CNT_W-1:0]      errs_q;
  logic [DATA_W-1:0]     exp_q;
  logic [DATA_W-1:0]     data_inc;
  logic [DATA_W-1:0]     fe_q;
  logic [DATA_W-1:0]     fa_q;
  logic [INTERVAL_W-1:0] ival_q;
  logic                  unused_ctrl;

  assign enable      = control[0];
  assign clear       = control[1];
  assign unused_ctrl = ^control[31:2];

  assign active   = (state_q == SYNC) || (state_q == CHECK);
  // Gate on live control so a disabled/clearing checker never advances the source
  assign strobe   = active && enable && !clear && (ival_q == '0);
  assign data_inc = data + DATA_W'(1);
  assign mismatch = (state_q == CHECK) && (data != exp_q);

  always_comb begin
    words_nx = words_q;
    if (state_q == SYNC)
      words_nx = CNT_W'(1);
    else if (words_q != '1)
      words_nx = words_q + CNT_W'(1);
  end

  assign last_word = (num_words != '0) && (words_nx == num_words);

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = enable ? SYNC : IDLE;
    end else begin
      unique case (state_q)
        IDLE: if (enable) state_d = SYNC;
        SYNC, CHECK: begin
          if (!enable)
            state_d = IDLE;
          else if (strobe)
            state_d = last_word ? DONE : CHECK;
        end
        DONE: if (!enable) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge axi_clk) begin
    if (axi_reset) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      synced_q   <= 1'b0;
      err_seen_q <= 1'b0;
      words_q    <= '0;
      errs_q     <= '0;
      exp_q      <= '0;
      fe_q       <= '0;
      fa_q       <= '0;
      ival_q     <= '0;
    end else begin
      state_q  <= state_d;
      busy_q   <= (state_d == SYNC) || (state_d == CHECK);
      synced_q <= (state_d == CHECK) || (state_d == DONE);
      done_q   <= (state_d == DONE);
      if (clear) begin
        err_seen_q <= 1'b0;
        words_q    <= '0;
        errs_q     <= '0;
        fe_q       <= '0;
        fa_q       <= '0;
        ival_q     <= '0;
      end else if (strobe) begin
        ival_q  <= rd_interval;
        words_q <= words_nx;
        // Match or mismatch, the next expected word follows the sampled one
        exp_q   <= data_inc;
        if (mismatch) begin
          if (errs_q != '1)
            errs_q <= errs_q + CNT_W'(1);
          if (!err_seen_q) begin
            fe_q       <= exp_q;
            fa_q       <= data;
            err_seen_q <= 1'b1;
          end
        end
      end else if (!active) begin
        ival_q <= '0;
      end else if (ival_q != '0) begin
        ival_q <= ival_q - INTERVAL_W'(1);
      end
    end
  end

  assign data_rdStrobe      = strobe;
  assign status             = {28'd0, synced_q, err_seen_q, done_q, busy_q};
  assign words_checked      = words_q;
  assign error_count        = errs_q;
  assign first_err_expected = fe_q;
  assign first_err_actual   = fa_q;

endmodule

// File: tb/tb_test_data_checker.sv
// Bench for test_data_checker: table cases, random sequences vs a
// sequence-level model, and hand-written disable/clear/reset scenarios.
module tb_test_data_checker;

  logic        axi_clk = 1'b0;
  logic        axi_reset;
  logic [31:0] control;
  logic [31:0] num_words;
  logic [7:0]  rd_interval;
  logic [31:0] data;
  logic        data_rdStrobe;
  logic [31:0] status;
  logic [31:0] words_checked;
  logic [31:0] error_count;
  logic [31:0] first_err_expected;
  logic [31:0] first_err_actual;

  logic [31:0] src_mem [0:255];
  int          src_idx = 0;
  logic        src_rst;
  int          cyc = 0;
  int          stb_log[$];
  int          n_checks = 0;
  int          n_errors = 0;

  test_data_checker dut (
    .axi_clk            (axi_clk),
    .axi_reset          (axi_reset),
    .control            (control),
    .num_words          (num_words),
    .rd_interval        (rd_interval),
    .data               (data),
    .data_rdStrobe      (data_rdStrobe),
    .status             (status),
    .words_checked      (words_checked),
    .error_count        (error_count),
    .first_err_expected (first_err_expected),
    .first_err_actual   (first_err_actual)
  );

  always #5 axi_clk = ~axi_clk;

  assign data = src_mem[src_idx[7:0]];

  // Source model: advances after every strobe edge
  always @(posedge axi_clk) begin
    cyc <= cyc + 1;
    if (src_rst)
      src_idx <= 0;
    else if (data_rdStrobe) begin
      src_idx <= src_idx + 1;
      stb_log.push_back(cyc);
    end
  end

  typedef struct {
    int          ival;
    int          n;
    logic [31:0] start;
    int          skip_idx;
    logic [31:0] skip;
    int          ee;
    logic [31:0] efe;
    logic [31:0] efa;
  } vec_t;

  vec_t tbl[5];

  task automatic tick();
    @(posedge axi_clk);
    #1;
  endtask

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic fill_inc(logic [31:0] start);
    for (int i = 0; i < 256; i++)
      src_mem[i] = start + 32'(i);
  endtask

  function automatic logic spacing_ok(int gap);
    for (int i = 1; i < stb_log.size(); i++)
      if (stb_log[i] - stb_log[i-1] != gap)
        return 1'b0;
    return 1'b1;
  endfunction

  // Resyncing checker: word i is wrong iff it is not word i-1 plus one
  task automatic model(int n, output int e,
                       output logic [31:0] fe, output logic [31:0] fa);
    e  = 0;
    fe = 0;
    fa = 0;
    for (int i = 1; i < n; i++)
      if (src_mem[i] !== src_mem[i-1] + 32'd1) begin
        if (e == 0) begin
          fe = src_mem[i-1] + 32'd1;
          fa = src_mem[i];
        end
        e++;
      end
  endtask

  task automatic clear_all();
    control = 32'd2;
    src_rst = 1'b1;
    tick();
    control = 32'd0;
    src_rst = 1'b0;
    stb_log.delete();
  endtask

  task automatic run_case(string nm, int ival, int n, int ee,
                          logic [31:0] efe, logic [31:0] efa);
    logic done_seen;
    clear_all();
    rd_interval = 8'(ival);
    num_words   = 32'(n);
    control     = 32'd1;
    done_seen   = 1'b0;
    for (int k = 0; k < n * (ival + 1) + 10; k++) begin
      tick();
      if (status[1]) begin
        done_seen = 1'b1;
        break;
      end
    end
    check({nm, "_done"}, 32'(done_seen), 32'd1);
    check({nm, "_status"}, status, (ee != 0) ? 32'hE : 32'hA);
    check({nm, "_words"}, words_checked, 32'(n));
    check({nm, "_errs"}, error_count, 32'(ee));
    check({nm, "_fe"}, first_err_expected, efe);
    check({nm, "_fa"}, first_err_actual, efa);
    check({nm, "_nstb"}, 32'(stb_log.size()), 32'(n));
    check({nm, "_gap"}, 32'(spacing_ok(ival + 1)), 32'd1);
    repeat (3) tick();
    check({nm, "_quiet"}, 32'(stb_log.size()), 32'(n));
    control = 32'd0;
    tick();
  endtask

  initial begin
    int          e;
    int          idx;
    logic [31:0] fe;
    logic [31:0] fa;
    logic        ok;

    axi_reset   = 1'b1;
    control     = 32'd0;
    num_words   = 32'd0;
    rd_interval = 8'd0;
    src_rst     = 1'b1;
    fill_inc(0);
    tick();
    tick();
    check("rst_status", status, 32'd0);
    check("rst_words", words_checked, 32'd0);
    check("rst_errs", error_count, 32'd0);
    check("rst_fe_fa", first_err_expected | first_err_actual, 32'd0);
    check("rst_stb", 32'(data_rdStrobe), 32'd0);
    axi_reset = 1'b0;
    src_rst   = 1'b0;

    tbl[0] = '{0, 8, 32'd0, -1, 32'd0, 0, 32'd0, 32'd0};
    tbl[1] = '{0, 6, 32'd5, 3, 32'd1, 1, 32'd8, 32'd9};
    tbl[2] = '{0, 4, 32'hFFFF_FFFE, -1, 32'd0, 0, 32'd0, 32'd0};
    tbl[3] = '{2, 5, 32'd100, 1, 32'd5, 1, 32'd101, 32'd106};
    tbl[4] = '{1, 1, 32'd7, -1, 32'd0, 0, 32'd0, 32'd0};
    for (int t = 0; t < 5; t++) begin
      for (int i = 0; i < 256; i++) begin
        src_mem[i] = tbl[t].start + 32'(i);
        if (tbl[t].skip_idx >= 0 && i >= tbl[t].skip_idx)
          src_mem[i] = src_mem[i] + tbl[t].skip;
      end
      run_case($sformatf("tbl%0d", t), tbl[t].ival, tbl[t].n,
               tbl[t].ee, tbl[t].efe, tbl[t].efa);
    end

    for (int r = 0; r < 25; r++) begin
      int ival;
      int n;
      ival = int'($urandom_range(0, 3));
      n    = int'($urandom_range(1, 16));
      fill_inc($urandom);
      for (int i = 0; i < 256; i++)
        if ($urandom_range(0, 5) == 0)
          src_mem[i] = $urandom;
      model(n, e, fe, fa);
      run_case($sformatf("rand%0d", r), ival, n, e, fe, fa);
    end

    // Free-running with spacing of 4
    clear_all();
    fill_inc(0);
    rd_interval = 8'd3;
    num_words   = 32'd0;
    control     = 32'd1;
    repeat (40) tick();
    check("free_status", status, 32'h9);
    check("free_gap", 32'(spacing_ok(4)), 32'd1);
    check("free_nstb", 32'(stb_log.size() >= 9), 32'd1);
    check("free_errs", error_count, 32'd0);
    control = 32'd0;
    tick();

    // Disable after three words, clear, then re-enable
    clear_all();
    fill_inc(0);
    rd_interval = 8'd0;
    num_words   = 32'd0;
    control     = 32'd1;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (src_idx == 3) begin
        ok = 1'b1;
        break;
      end
    end
    check("dis_reach3", 32'(ok), 32'd1);
    control = 32'd0;
    tick();
    check("dis_words", words_checked, 32'd3);
    repeat (4) tick();
    check("dis_src", 32'(src_idx), 32'd3);
    check("dis_status", status, 32'd0);
    control = 32'd2;
    tick();
    control = 32'd0;
    check("clr_words", words_checked, 32'd0);
    check("clr_errs", error_count, 32'd0);
    num_words = 32'd4;
    control   = 32'd1;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (status[1]) begin
        ok = 1'b1;
        break;
      end
    end
    check("reen_done", 32'(ok), 32'd1);
    check("reen_words", words_checked, 32'd4);
    check("reen_errs", error_count, 32'd0);
    check("reen_status", status, 32'hA);
    control = 32'd0;
    tick();

    // Reset in the middle of checking with an error already latched
    clear_all();
    fill_inc(0);
    src_mem[3]  = 32'd77;
    rd_interval = 8'd0;
    num_words   = 32'd0;
    control     = 32'd1;
    repeat (8) tick();
    check("mid_errseen", 32'(status[2]), 32'd1);
    check("mid_fa", first_err_actual, 32'd77);
    axi_reset = 1'b1;
    control   = 32'd0;
    tick();
    check("mid_rst_status", status, 32'd0);
    check("mid_rst_words", words_checked, 32'd0);
    check("mid_rst_errs", error_count, 32'd0);
    check("mid_rst_fe_fa", first_err_expected | first_err_actual, 32'd0);
    check("mid_rst_stb", 32'(data_rdStrobe), 32'd0);
    axi_reset = 1'b0;
    idx = src_idx;
    repeat (5) tick();
    check("mid_rst_src", 32'(src_idx), 32'(idx));
    check("mid_rst_idle", status, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
